// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Results are computed combinationally from the latched operands and the
// live {hi,lo} value, then written at the end of the latency window.
// Handshake: an op is accepted on a rising edge where start=1, int_clr=0,
// busy=0 and op is 1..10. busy is high from the cycle after acceptance
// until the completion edge. done/dz pulse for the single cycle that
// follows the completion edge. While busy=1, start is dropped, not queued.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             int_clr,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;

  // Datapath signals (all derived from latched operands)
  logic               mul_signed;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mul_res;
  logic               is_div;
  logic               div_signed;
  logic               b_zero;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  // Multiply/accumulate: sign- or zero-extend to 2*WIDTH so one truncated
  // product serves both signed and unsigned forms; accumulation wraps.
  always_comb begin
    mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    ext_a = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod  = ext_a * ext_b;
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = {hi, lo} + prod;
      OP_MSUB, OP_MSUBU: mul_res = {hi, lo} - prod;
      default:           mul_res = prod;
    endcase
  end

  // Divide on magnitudes, then restore signs: quotient truncates toward
  // zero, remainder follows the dividend. most-negative / -1 falls out
  // naturally as most-negative with remainder 0.
  always_comb begin
    is_div     = (op_q == OP_DIV) || (op_q == OP_DIVU);
    div_signed = (op_q == OP_DIV);
    b_zero     = (b_q == '0);
    a_neg      = div_signed && a_q[WIDTH-1];
    b_neg      = div_signed && b_q[WIDTH-1];
    mag_a      = a_neg ? -a_q : a_q;
    mag_b      = b_neg ? -b_q : b_q;
    if (b_zero) begin
      q_mag = '0;
      r_mag = '0;
    end else begin
      q_mag = mag_a / mag_b;
      r_mag = mag_a % mag_b;
    end
    quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem  = a_neg ? -r_mag : r_mag;
  end

  // Control FSM: accept, count down the latency, then commit HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
    end else begin
      done <= 1'b0;
      dz   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !int_clr) begin
            case (op)
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
              OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU: begin
                op_q  <= op;
                a_q   <= a;
                b_q   <= b;
                cnt   <= ((op == OP_DIV) || (op == OP_DIVU)) ? CW'(DIV_CYCLES)
                                                             : CW'(MUL_CYCLES);
                busy  <= 1'b1;
                state <= S_RUN;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (cnt == CW'(1)) begin
            if (is_div) begin
              if (!b_zero) begin
                lo <= quot;
                hi <= rem;
              end
              dz <= b_zero;
            end else begin
              {hi, lo} <= mul_res;
            end
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vectors, scoreboard queue of expected
// {hi,lo,dz}, monitor pops on every done pulse.
module tb_muldiv_unit;

  localparam int W  = 32;
  localparam int NM = 5;
  localparam int ND = 10;
  localparam int EW = 2 * W + 1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  logic         clk;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         int_clr;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         dz;

  logic [EW-1:0] exp_q[$];
  int total;
  int bad;

  muldiv_unit #(.WIDTH(W), .MUL_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .int_clr(int_clr), .hi(hi), .lo(lo), .busy(busy), .done(done), .dz(dz)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("sb_hi", 64'(hi), 64'(e[EW-1:W+1]));
          check("sb_lo", 64'(lo), 64'(e[W:1]));
          check("sb_dz", 64'(dz), 64'(e[0]));
        end
      end else if (dz) begin
        check("dz_without_done", 64'd1, 64'd0);
      end
    end
  end

  // Drive one issue cycle; returns at the negedge after the sampling edge,
  // with operands scrambled to prove they were latched.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic clr);
    @(negedge clk);
    start = 1'b1; op = o; a = aa; b = bb; int_clr = clr;
    @(negedge clk);
    start = 1'b0; op = 4'd0; int_clr = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  // Count negedges with busy high, bounded
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic run_arith(input string name, input logic [3:0] o,
                           input logic [W-1:0] aa, input logic [W-1:0] bb,
                           input logic [W-1:0] ehi, input logic [W-1:0] elo,
                           input logic edz, input int n);
    int c;
    exp_q.push_back({ehi, elo, edz});
    issue(o, aa, bb, 1'b0);
    wait_idle(c);
    check({name, "_busy_cycles"}, 64'(c), 64'(n));
    @(negedge clk);
    check({name, "_hold"}, {hi, lo}, {ehi, elo});
  endtask

  task automatic move(input logic [3:0] o, input logic [W-1:0] v);
    issue(o, v, '0, 1'b0);
    check("move_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int c;
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0; int_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_flags", {61'd0, busy, done, dz}, 64'd0);
    reset = 1'b0;

    // Multiplies
    run_arith("mult_signed", OP_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, NM);
    run_arith("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, NM);

    // Divides
    run_arith("divu_7_2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, ND);
    run_arith("div_neg7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, ND);
    run_arith("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, ND);
    run_arith("divu_big", OP_DIVU, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, 1'b0, ND);

    // Accumulate with carry and borrow across the hi/lo boundary
    move(OP_MTHI, 32'd0);
    move(OP_MTLO, 32'hFFFFFFFF);
    check("mt_hi", 64'(hi), 64'd0);
    check("mt_lo", 64'(lo), 64'hFFFFFFFF);
    run_arith("maddu_carry", OP_MADDU, 32'd1, 32'd1, 32'd1, 32'd0, 1'b0, NM);
    run_arith("msubu_borrow", OP_MSUBU, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0, NM);
    run_arith("madd_signed", OP_MADD, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFD, 1'b0, NM);
    run_arith("msub_signed", OP_MSUB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFC, 1'b0, NM);

    // Divide by zero keeps hi/lo
    move(OP_MTHI, 32'h11);
    move(OP_MTLO, 32'h22);
    run_arith("div_by_zero", OP_DIV, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, ND);

    // Flush in the issue cycle: nothing accepted
    issue(OP_MULT, 32'd2, 32'd3, 1'b1);
    check("flush_busy", 64'(busy), 64'd0);
    issue(OP_MTHI, 32'h99, 32'd0, 1'b1);
    repeat (NM + 2) @(negedge clk);
    check("flush_hilo", {hi, lo}, {32'h11, 32'h22});

    // Flush mid-run does not abort; starts during busy are dropped
    exp_q.push_back({32'd0, 32'd6, 1'b0});
    issue(OP_MULT, 32'd2, 32'd3, 1'b0);
    int_clr = 1'b1;
    @(negedge clk);
    int_clr = 1'b0; start = 1'b1; op = OP_MULT; a = 32'd100; b = 32'd100;
    @(negedge clk);
    op = OP_MTLO; a = 32'h55;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    wait_idle(c);
    check("midrun_busy_cycles", 64'(c), 64'(NM - 3));
    repeat (NM + 2) @(negedge clk);
    check("midrun_hilo", {hi, lo}, {32'd0, 32'd6});

    // Reset in the middle of a divide: no done, registers cleared
    move(OP_MTLO, 32'h77);
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_flags", {61'd0, busy, done, dz}, 64'd0);
    repeat (ND + 3) @(negedge clk);
    check("rst_mid_busy_after", 64'(busy), 64'd0);
    run_arith("mult_after_rst", OP_MULT, 32'd4, 32'd5, 32'd0, 32'd20, 1'b0, NM);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
